mips_cpu_regfile_mp: RTL

MIPS_CPU_REGFILE_MP -- requirements
Module: mips_cpu_regfile_mp

---
 rtl/mips_cpu_pkg.sv | 23 ++
 rtl/mips_cpu_regfile_dump.sv | 78 +++++++
 rtl/mips_cpu_regfile_mp.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_pkg
// Brief   : Shared types and default constants for the MIPS register file.
// Revision: 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_NUM_READ_PORTS = 2;
    localparam int DEF_BYPASS         = 1;
    localparam int DEF_ZERO_REG       = 1;
    localparam int DEF_V0_INDEX       = 2;

    typedef enum logic [1:0] {
        DUMP_IDLE   = 2'd0,
        DUMP_STREAM = 2'd1,
        DUMP_DONE   = 2'd2
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_regfile_dump
// Brief   : Register-dump sequencer: walks indices 0..DEPTH-1 with a
//           valid/ready handshake and pulses done once at the end.
// Revision: 1.0 - initial release
// ============================================================================
module mips_cpu_regfile_dump
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic                  dump_busy,
    output logic                  dump_done,
    output logic [ADDR_WIDTH-1:0] dump_index
);

    dump_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // The index is cleared on every exit from STREAM so IDLE/DONE present 0.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_STREAM;
                    index_d = '0;
                end
            end
            DUMP_STREAM: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (index_q == '1) begin
                        state_d = DUMP_DONE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DUMP_DONE: begin
                dump_done = 1'b1;
                dump_busy = 1'b1;
                state_d   = DUMP_IDLE;
                index_d   = '0;
            end
            default: begin
                state_d = DUMP_IDLE;
                index_d = '0;
            end
        endcase
    end

    assign dump_index = index_q;

endmodule
`default_nettype wire

// File: rtl/mips_cpu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_regfile_mp
// Brief   : Dual-write, multi-read MIPS register file with optional write
//           forwarding, hardwired zero register, v0 tap and dump streamer.
// Revision: 1.0 - initial release
// ============================================================================
module mips_cpu_regfile_mp
    import mips_cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS,
    parameter int BYPASS         = DEF_BYPASS,
    parameter int ZERO_REG       = DEF_ZERO_REG,
    parameter int V0_INDEX       = DEF_V0_INDEX
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      write_enable_0,
    input  logic                                      write_enable_1,
    input  logic [ADDR_WIDTH-1:0]                     write_reg_0,
    input  logic [ADDR_WIDTH-1:0]                     write_reg_1,
    input  logic [DATA_WIDTH-1:0]                     write_data_0,
    input  logic [DATA_WIDTH-1:0]                     write_data_1,
    input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0] read_reg,
    output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0]                     read_data_v0,
    input  logic                                      dump_start,
    input  logic                                      dump_ready,
    output logic                                      dump_valid,
    output logic [ADDR_WIDTH-1:0]                     dump_index,
    output logic [DATA_WIDTH-1:0]                     dump_data,
    output logic                                      dump_busy,
    output logic                                      dump_done
);

    localparam int                    c_depth   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_v0_addr = ADDR_WIDTH'(V0_INDEX);
    localparam logic                  c_zero_en = (ZERO_REG != 0);
    localparam logic                  c_byp_en  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_q [c_depth];
    logic                  w_wr0_ok;
    logic                  w_wr1_ok;

    // A write aimed at the hardwired zero register is dropped everywhere,
    // including the forwarding path.
    assign w_wr0_ok = write_enable_0 && !(c_zero_en && (write_reg_0 == '0));
    assign w_wr1_ok = write_enable_1 && !(c_zero_en && (write_reg_1 == '0));

    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < c_depth; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            if (w_wr0_ok) regs_q[write_reg_0] <= write_data_0;
            if (w_wr1_ok) regs_q[write_reg_1] <= write_data_1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
            always_comb begin
                read_data[gi] = regs_q[read_reg[gi]];
                if (c_zero_en && (read_reg[gi] == '0)) begin
                    read_data[gi] = '0;
                end else if (c_byp_en && w_wr1_ok && (write_reg_1 == read_reg[gi])) begin
                    read_data[gi] = write_data_1;
                end else if (c_byp_en && w_wr0_ok && (write_reg_0 == read_reg[gi])) begin
                    read_data[gi] = write_data_0;
                end
            end
        end
    endgenerate

    assign read_data_v0 = regs_q[c_v0_addr];

    mips_cpu_regfile_dump #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dump (
        .clk        (clk),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_index (dump_index)
    );

    assign dump_data = (c_zero_en && (dump_index == '0)) ? '0 : regs_q[dump_index];

endmodule
`default_nettype wire
